// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words MSB-first into a serial configuration chain.
// An optional verify pass compares the returning tail against the bits being shifted.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int              WCW        = $clog2(WORD_W + 1);
  localparam logic [WCW-1:0]  WORD_LAST  = WCW'(WORD_W - 1);
  localparam logic [15:0]     CHAIN_LAST = 16'(CHAIN_LEN - 1);

  state_t              state, state_d;
  logic [WORD_W-1:0]   sr, sr_d;
  logic [WCW-1:0]      wcnt, wcnt_d;
  logic [15:0]         cnt_d;
  logic                head_d;
  logic                err_d;
  logic                mode, mode_d;

  // Next-state and datapath. The head only changes when another bit of the
  // same word follows, so it stays put across LOAD stalls and pass ends.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state;
    sr_d    = sr;
    wcnt_d  = wcnt;
    cnt_d   = bit_cnt;
    head_d  = ccff_head;
    err_d   = err;
    mode_d  = mode;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
          mode_d  = verify;
        end
      end

      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bs_valid) begin
          sr_d    = bs_data;
          head_d  = bs_data[WORD_W-1];
          wcnt_d  = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (mode && ccff_shift_en && (ccff_tail != ccff_head)) begin
          err_d = 1'b1;
        end
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d  = bit_cnt + 16'd1;
          wcnt_d = wcnt + WCW'(1);
          sr_d   = sr << 1;
          if (bit_cnt == CHAIN_LAST) begin
            state_d = DONE;
          end else if (wcnt == WORD_LAST) begin
            state_d = LOAD;
          end else begin
            head_d = sr_d[WORD_W-1];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs are flops whose next value is decoded from the next state.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state         <= IDLE;
      sr            <= '0;
      wcnt          <= '0;
      mode          <= 1'b0;
      bit_cnt       <= '0;
      err           <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      bs_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state         <= state_d;
      sr            <= sr_d;
      wcnt          <= wcnt_d;
      mode          <= mode_d;
      bit_cnt       <= cnt_d;
      err           <= err_d;
      ccff_head     <= head_d;
      ccff_shift_en <= (state_d == SHIFT);
      bs_ready      <= (state_d == LOAD);
      busy          <= (state_d != IDLE);
      done          <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed and randomized bench for ccff_bitstream_loader with a serial chain
// model on the tail and a word-to-bitstream reference built by plain indexing.
module tb_ccff_bitstream_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;

  typedef logic [WW-1:0] word_arr_t [NW];

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b1;
  logic          start    = 1'b0;
  logic          verify   = 1'b0;
  logic          abort    = 1'b0;
  logic [WW-1:0] bs_data  = '0;
  logic          bs_valid = 1'b0;
  logic          bs_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic          busy, done, err;
  logic [15:0]   bit_cnt;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  bit obs[$];
  logic [CL-1:0] chain = '0;

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .verify        (verify),
    .abort         (abort),
    .bs_data       (bs_data),
    .bs_valid      (bs_valid),
    .bs_ready      (bs_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .bit_cnt       (bit_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  // Configuration chain: a plain CL-bit shift register.
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) if (ccff_shift_en === 1'b1) chain <= {chain[CL-2:0], ccff_head};

  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) obs.push_back(ccff_head);
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CL-1:0] model_stream(input word_arr_t w);
    logic [CL-1:0] r;
    for (int i = 0; i < CL; i++) r[CL-1-i] = w[i / WW][WW-1-(i % WW)];
    return r;
  endfunction

  function automatic logic [CL-1:0] obs_vec();
    logic [CL-1:0] r = '0;
    for (int i = 0; i < CL && i < obs.size(); i++) r[CL-1-i] = obs[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bs_ready && n < 100) begin tick(); n++; end
    check("ready_seen", 32'(bs_ready), 1);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap);
    bs_valid = 1'b0;
    repeat (gap) tick();
    bs_data  = w;
    bs_valid = 1'b1;
    wait_ready();
    tick();
    bs_valid = 1'b0;
    bs_data  = WW'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin tick(); n++; end
    check("done_seen", 32'(done), 1);
    tick();
    check("done_one_cycle", 32'(done), 0);
  endtask

  task automatic run_pass(input logic v, input word_arr_t w, input int gap_max,
                          input bit stall, input bit poke, input bit with_abort,
                          input string tag);
    int   d0;
    logic h;
    obs.delete();
    d0       = done_cnt;
    start    = 1'b1;
    verify   = v;
    abort    = with_abort;
    tick();
    start    = 1'b0;
    abort    = 1'b0;
    verify   = 1'($urandom);
    check({tag, "_start_cnt"}, 32'(bit_cnt), 0);
    check({tag, "_start_busy"}, 32'(busy), 1);
    for (int k = 0; k < NW; k++) begin
      if (stall && k > 0) begin
        wait_ready();
        h = ccff_head;
        for (int j = 0; j < 5; j++) begin
          check({tag, "_stall_en"}, 32'(ccff_shift_en), 0);
          check({tag, "_stall_head"}, 32'(ccff_head), 32'(h));
          tick();
        end
      end
      send_word(w[k], stall ? 0 : int'($urandom_range(gap_max, 0)));
      if (poke && k == 0) begin
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_no_restart"}, 32'(bit_cnt), 2);
      end
    end
    wait_done();
    check({tag, "_nbits"}, 32'(obs.size()), CL);
    check({tag, "_stream"}, 32'(obs_vec()), 32'(model_stream(w)));
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    check({tag, "_bit_cnt"}, 32'(bit_cnt), CL);
    check({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bs_ready), 0);
    check({tag, "_head"}, 32'(ccff_head), 0);
    check({tag, "_shift_en"}, 32'(ccff_shift_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
  endtask

  initial begin
    word_arr_t dir_w;
    word_arr_t rw;
    int        n;
    int        d0;
    dir_w = '{8'hA5, 8'h3C, 8'hF0};

    // Reset state.
    #12;
    check_all_zero("reset");
    pReset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Plain load of the directed words.
    run_pass(1'b0, dir_w, 0, 1'b0, 1'b0, 1'b0, "load");
    check("load_literal", 32'(obs_vec()), 32'(20'b1010_0101_0011_1100_1111));
    check("load_err", 32'(err), 0);

    // Identical verify pass.
    run_pass(1'b1, dir_w, 2, 1'b0, 1'b0, 1'b0, "verify_ok");
    check("verify_ok_err", 32'(err), 0);

    // Verify with a corrupted first word: last bit of that word differs.
    obs.delete();
    d0     = done_cnt;
    start  = 1'b1;
    verify = 1'b1;
    tick();
    start  = 1'b0;
    verify = 1'b0;
    send_word(8'hA4, 0);
    repeat (7) tick();
    check("mis_cnt7", 32'(bit_cnt), 7);
    check("mis_err_before", 32'(err), 0);
    tick();
    check("mis_cnt8", 32'(bit_cnt), 8);
    check("mis_err_after", 32'(err), 1);
    send_word(8'h3C, 0);
    send_word(8'hF0, 0);
    wait_done();
    check("mis_err_end", 32'(err), 1);
    check("mis_done_pulses", 32'(done_cnt - d0), 1);
    check("mis_bit_cnt", 32'(bit_cnt), CL);

    // Back-pressure: five idle LOAD cycles before each later word.
    run_pass(1'b0, dir_w, 0, 1'b1, 1'b0, 1'b0, "bp");

    // Abort after 11 bits.
    obs.delete();
    d0    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_err", 32'(err), 0);
    send_word(8'h5A, 0);
    send_word(8'hC3, 0);
    n = 0;
    while (bit_cnt != 16'd11 && n < 50) begin tick(); n++; end
    check("abort_reach11", 32'(bit_cnt), 11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_cnt", 32'(bit_cnt), 11);
    check("abort_shift_en", 32'(ccff_shift_en), 0);
    tick();
    check("abort_no_done", 32'(done_cnt - d0), 0);

    // New start after abort; then abort in LOAD beats a valid word.
    obs.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_cnt", 32'(bit_cnt), 0);
    check("restart_ready", 32'(bs_ready), 1);
    bs_data  = 8'hFF;
    bs_valid = 1'b1;
    abort    = 1'b1;
    tick();
    bs_valid = 1'b0;
    abort    = 1'b0;
    check("load_abort_busy", 32'(busy), 0);
    repeat (3) tick();
    check("load_abort_noshift", 32'(obs.size()), 0);
    check("load_abort_cnt", 32'(bit_cnt), 0);

    // Start together with abort in IDLE, plus a start pulse mid-pass.
    rw = '{8'h96, 8'h0F, 8'h7E};
    run_pass(1'b0, rw, 1, 1'b0, 1'b1, 1'b1, "start_abort");

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(8'hFF, 0);
    repeat (3) tick();
    check("pre_rst_shift_en", 32'(ccff_shift_en), 1);
    #3;
    pReset = 1'b1;
    #2;
    check_all_zero("async_rst");
    start = 1'b1;
    tick();
    tick();
    check("rst_start_ignored", 32'(busy), 0);
    start = 1'b0;
    #3;
    pReset = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 0);
    run_pass(1'b0, dir_w, 1, 1'b0, 1'b0, 1'b0, "post_rst");

    // Randomized load/verify pairs.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) rw[k] = WW'($urandom);
      run_pass(1'b0, rw, 3, 1'b0, bit'(r & 1), 1'b0, "rnd_load");
      run_pass(1'b1, rw, 3, 1'b0, 1'b0, 1'b0, "rnd_verify");
      check("rnd_verify_err", 32'(err), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
